m1m3_iso_sequencer: RTL and testbench

//  Power/isolation sequencer for the M1->M3 link (MyBus dataReady->dataTx path). Drives isolateM1M3 and
//  the M1-domain power switch in safe order: drain link, isolate, switch off; and reverse on wake.

---
 rtl/m1m3_pwr_pkg.sv | 50 +++++
 rtl/m1m3_iso_sequencer_if.sv | 23 ++
 rtl/m1m3_seq_timer.sv | 31 +++
 rtl/m1m3_iso_sequencer.sv | 168 ++++++++++++++++
 tb/tb_m1m3_iso_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/m1m3_pwr_pkg.sv
// Shared types, default timing constants and output decode for the M1->M3
// isolation/power sequencer.
package m1m3_pwr_pkg;

   typedef enum logic [2:0] {
      OFF          = 3'd0,
      PWR_ON_WAIT  = 3'd1,
      DEISO        = 3'd2,
      ON           = 3'd3,
      DRAIN        = 3'd4,
      ISO          = 3'd5,
      PWR_OFF_WAIT = 3'd6
   } m1m3_pwr_state_e;

   typedef struct packed {
      logic iso;
      logic en;
      logic hold;
   } m1m3_pwr_out_t;

   localparam int DRAIN_CYCLES_DEF      = 4;
   localparam int PWR_SETTLE_CYCLES_DEF = 8;
   localparam int ACK_TIMEOUT_DEF       = 16;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // One spare bit so a counter can hold its limit value without wrapping.
   function automatic int cnt_width(input int a, input int b, input int c);
      return $clog2(max3(a, b, c)) + 1;
   endfunction

   function automatic m1m3_pwr_out_t state_outputs(input m1m3_pwr_state_e st);
      m1m3_pwr_out_t o;
      case (st)
         PWR_ON_WAIT:  begin o.iso = 1'b1; o.en = 1'b1; o.hold = 1'b1; end
         DEISO:        begin o.iso = 1'b0; o.en = 1'b1; o.hold = 1'b1; end
         ON:           begin o.iso = 1'b0; o.en = 1'b1; o.hold = 1'b0; end
         DRAIN:        begin o.iso = 1'b0; o.en = 1'b1; o.hold = 1'b1; end
         ISO:          begin o.iso = 1'b1; o.en = 1'b1; o.hold = 1'b1; end
         PWR_OFF_WAIT: begin o.iso = 1'b1; o.en = 1'b0; o.hold = 1'b1; end
         default:      begin o.iso = 1'b1; o.en = 1'b0; o.hold = 1'b1; end
      endcase
      return o;
   endfunction

endpackage

// File: rtl/m1m3_iso_sequencer_if.sv
// Request/status bundle between the always-on controller, M1 and the power switch.
interface m1m3_iso_sequencer_if;
   logic       req_pwr_down;
   logic       req_pwr_up;
   logic       link_busy;
   logic       pwr_ack;
   logic       isolateM1M3;
   logic       pwr_en;
   logic       link_hold;
   logic       seq_done;
   logic       seq_err;
   logic [2:0] state_o;

   modport master (
      output req_pwr_down, req_pwr_up, link_busy, pwr_ack,
      input  isolateM1M3, pwr_en, link_hold, seq_done, seq_err, state_o
   );

   modport slave (
      input  req_pwr_down, req_pwr_up, link_busy, pwr_ack,
      output isolateM1M3, pwr_en, link_hold, seq_done, seq_err, state_o
   );
endinterface

// File: rtl/m1m3_seq_timer.sv
// Saturating up-counter with synchronous clear/enable; expire is high once
// the count has reached the limit and stays there until cleared.
module m1m3_seq_timer #(
   parameter int CNT_W = 5
) (
   input  logic             ck,
   input  logic             arst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_limit,
   output logic             o_expire
);

   logic [CNT_W-1:0] r_count;

   // count register: clear wins, then saturating increment
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count < i_limit)) begin
         r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         r_count <= r_count;
      end
   end

   assign o_expire = (r_count >= i_limit);

endmodule

// File: rtl/m1m3_iso_sequencer.sv
// Always-on sequencer for the M1->M3 link: drain, isolate, switch off, and the
// reverse on wake. Moore machine; every output comes straight from a flop.
module m1m3_iso_sequencer
   import m1m3_pwr_pkg::*;
#(
   parameter int DRAIN_CYCLES      = DRAIN_CYCLES_DEF,
   parameter int PWR_SETTLE_CYCLES = PWR_SETTLE_CYCLES_DEF,
   parameter int ACK_TIMEOUT       = ACK_TIMEOUT_DEF
) (
   input logic                  ck,
   input logic                  arst,
   m1m3_iso_sequencer_if.slave  bus
);

   localparam int CNT_W = cnt_width(DRAIN_CYCLES, PWR_SETTLE_CYCLES, ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] L_DRAIN   = CNT_W'(DRAIN_CYCLES);
   localparam logic [CNT_W-1:0] L_SETTLE  = CNT_W'(PWR_SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(ACK_TIMEOUT);

   m1m3_pwr_state_e  r_state;
   m1m3_pwr_state_e  w_next;
   m1m3_pwr_out_t    w_out;
   logic             r_iso;
   logic             r_en;
   logic             r_hold;
   logic             r_done;
   logic             r_err;
   logic             w_done;
   logic             w_err_nxt;
   logic             w_to_clr;
   logic             w_to_en;
   logic             w_to_exp;
   logic             w_cnt_clr;
   logic             w_cnt_en;
   logic             w_cnt_exp;
   logic [CNT_W-1:0] w_cnt_limit;

   // ack timeout: runs only while waiting on the power switch
   m1m3_seq_timer #(.CNT_W(CNT_W)) u_timeout (
      .ck       (ck),
      .arst     (arst),
      .i_clr    (w_to_clr),
      .i_en     (w_to_en),
      .i_limit  (L_TIMEOUT),
      .o_expire (w_to_exp)
   );

   // shared settle (PWR_ON_WAIT) / idle (DRAIN) run-length counter
   m1m3_seq_timer #(.CNT_W(CNT_W)) u_runlen (
      .ck       (ck),
      .arst     (arst),
      .i_clr    (w_cnt_clr),
      .i_en     (w_cnt_en),
      .i_limit  (w_cnt_limit),
      .o_expire (w_cnt_exp)
   );

   // next-state, counter control, done pulse and error flag
   always_comb begin
      w_next      = r_state;
      w_done      = 1'b0;
      w_err_nxt   = r_err;
      w_to_clr    = 1'b1;
      w_to_en     = 1'b0;
      w_cnt_clr   = 1'b1;
      w_cnt_en    = 1'b0;
      w_cnt_limit = L_SETTLE;
      case (r_state)
         OFF: begin
            if (bus.req_pwr_up && !bus.req_pwr_down) begin
               w_next    = PWR_ON_WAIT;
               w_err_nxt = 1'b0;
            end else begin
               w_next = OFF;
            end
         end
         PWR_ON_WAIT: begin
            w_to_clr  = 1'b0;
            w_to_en   = 1'b1;
            w_cnt_clr = !bus.pwr_ack;
            w_cnt_en  = bus.pwr_ack;
            if (bus.pwr_ack && w_cnt_exp) begin
               w_next = DEISO;
            end else if (w_to_exp) begin
               w_next    = OFF;
               w_done    = 1'b1;
               w_err_nxt = 1'b1;
            end else begin
               w_next = PWR_ON_WAIT;
            end
         end
         DEISO: begin
            w_next = ON;
            w_done = 1'b1;
         end
         ON: begin
            if (bus.req_pwr_down && !bus.req_pwr_up) begin
               w_next    = DRAIN;
               w_err_nxt = 1'b0;
            end else begin
               w_next = ON;
            end
         end
         DRAIN: begin
            w_cnt_limit = L_DRAIN;
            w_cnt_clr   = bus.link_busy;
            w_cnt_en    = !bus.link_busy;
            // abort back to ON never pulses done: the link was never isolated
            if (bus.req_pwr_up && !bus.req_pwr_down) begin
               w_next = ON;
            end else if (w_cnt_exp) begin
               w_next = ISO;
            end else begin
               w_next = DRAIN;
            end
         end
         ISO: begin
            w_next = PWR_OFF_WAIT;
         end
         PWR_OFF_WAIT: begin
            w_to_clr = 1'b0;
            w_to_en  = 1'b1;
            if (!bus.pwr_ack) begin
               w_next = OFF;
               w_done = 1'b1;
            end else if (w_to_exp) begin
               w_next    = OFF;
               w_done    = 1'b1;
               w_err_nxt = 1'b1;
            end else begin
               w_next = PWR_OFF_WAIT;
            end
         end
         default: begin
            w_next = OFF;
         end
      endcase
   end

   assign w_out = state_outputs(w_next);

   // state and output registers; reset forces the isolated/unpowered pattern at once
   always_ff @(posedge ck or posedge arst) begin
      if (arst) begin
         r_state <= OFF;
         r_iso   <= 1'b1;
         r_en    <= 1'b0;
         r_hold  <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_iso   <= w_out.iso;
         r_en    <= w_out.en;
         r_hold  <= w_out.hold;
         r_done  <= w_done;
         r_err   <= w_err_nxt;
      end
   end

   assign bus.isolateM1M3 = r_iso;
   assign bus.pwr_en      = r_en;
   assign bus.link_hold   = r_hold;
   assign bus.seq_done    = r_done;
   assign bus.seq_err     = r_err;
   assign bus.state_o     = r_state;

endmodule

// File: tb/tb_m1m3_iso_sequencer.sv
// Directed scoreboard bench for m1m3_iso_sequencer: each step queues the
// outputs expected after the next clock edge, then pops and compares them.
module tb_m1m3_iso_sequencer;
   import m1m3_pwr_pkg::*;

   logic ck = 1'b0;
   logic arst;

   m1m3_iso_sequencer_if bus ();

   m1m3_iso_sequencer dut (
      .ck   (ck),
      .arst (arst),
      .bus  (bus)
   );

   always #5 ck = ~ck;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic       done;
      logic       err;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   logic prev_iso  = 1'b1;
   logic prev_done = 1'b0;

   // {iso, en, hold} required in each state
   function automatic logic [2:0] ieh_of(input logic [2:0] st);
      case (st)
         3'd0:    return 3'b101;
         3'd1:    return 3'b111;
         3'd2:    return 3'b011;
         3'd3:    return 3'b010;
         3'd4:    return 3'b011;
         3'd5:    return 3'b111;
         3'd6:    return 3'b101;
         default: return 3'b101;
      endcase
   endfunction

   task automatic expect_st(input string tag, input logic [2:0] st, input logic done, input logic err);
      exp_t e;
      e.tag  = tag;
      e.st   = st;
      e.done = done;
      e.err  = err;
      sb_q.push_back(e);
   endtask

   task automatic score();
      exp_t       e;
      logic [7:0] obs;
      logic [7:0] want;
      while (sb_q.size() > 0) begin
         e    = sb_q.pop_front();
         obs  = {bus.state_o, bus.isolateM1M3, bus.pwr_en, bus.link_hold, bus.seq_done, bus.seq_err};
         want = {e.st, ieh_of(e.st), e.done, e.err};
         n_tests++;
         assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed st/iso/en/hold/done/err=%b required %b", e.tag, obs, want);
         end
      end
   endtask

   task automatic step(input string tag, input logic [2:0] st, input logic done, input logic err);
      expect_st(tag, st, done, err);
      @(posedge ck);
      #1;
      score();
   endtask

   // called at cycle c0 from OFF; pwr_ack rises in c3, DEISO in c12, ON in c13
   task automatic power_up(input string tag);
      bus.pwr_ack    = 1'b0;
      bus.req_pwr_up = 1'b1;
      step(tag, PWR_ON_WAIT, 1'b0, 1'b0);
      step(tag, PWR_ON_WAIT, 1'b0, 1'b0);
      step(tag, PWR_ON_WAIT, 1'b0, 1'b0);
      bus.pwr_ack = 1'b1;
      for (int i = 0; i < 8; i++) step(tag, PWR_ON_WAIT, 1'b0, 1'b0);
      step(tag, DEISO, 1'b0, 1'b0);
      step(tag, ON, 1'b1, 1'b0);
      step(tag, ON, 1'b0, 1'b0);
      bus.req_pwr_up = 1'b0;
   endtask

   // continuous invariants, sampled on the falling edge
   always @(negedge ck) begin
      if (arst) begin
         prev_iso  = 1'b1;
         prev_done = 1'b0;
      end else begin
         n_tests++;
         assert (bus.pwr_en === 1'b1 || bus.isolateM1M3 === 1'b1) else begin
            n_fail++;
            $error("FAIL inv_en_iso: observed en=%b iso=%b required iso=1 when en=0", bus.pwr_en, bus.isolateM1M3);
         end
         n_tests++;
         assert (!(prev_iso === 1'b1 && bus.isolateM1M3 === 1'b0) || bus.state_o === 3'(DEISO)) else begin
            n_fail++;
            $error("FAIL inv_iso_fall: observed state %0d at iso fall required %0d", bus.state_o, 3'(DEISO));
         end
         n_tests++;
         assert (!(prev_done === 1'b1 && bus.seq_done === 1'b1)) else begin
            n_fail++;
            $error("FAIL inv_done_width: observed seq_done high 2 cycles required 1");
         end
         prev_iso  = bus.isolateM1M3;
         prev_done = bus.seq_done;
      end
   end

   initial begin
      arst             = 1'b1;
      bus.req_pwr_down = 1'b0;
      bus.req_pwr_up   = 1'b0;
      bus.link_busy    = 1'b0;
      bus.pwr_ack      = 1'b0;
      repeat (2) @(posedge ck);
      #1;
      expect_st("reset_state", OFF, 1'b0, 1'b0);
      score();
      arst = 1'b0;
      step("off_idle", OFF, 1'b0, 1'b0);

      // power-down request is meaningless while already off
      bus.req_pwr_down = 1'b1;
      step("off_ignore_down", OFF, 1'b0, 1'b0);
      step("off_ignore_down", OFF, 1'b0, 1'b0);
      bus.req_pwr_down = 1'b0;

      power_up("power_up");

      // both requests while ON: no movement
      bus.req_pwr_up   = 1'b1;
      bus.req_pwr_down = 1'b1;
      for (int i = 0; i < 3; i++) step("both_in_on", ON, 1'b0, 1'b0);
      bus.req_pwr_up   = 1'b0;
      bus.req_pwr_down = 1'b0;

      // drain: 10 busy cycles (with a simultaneous-request cycle), then 4 idle
      bus.req_pwr_down = 1'b1;
      bus.link_busy    = 1'b1;
      step("drain_entry", DRAIN, 1'b0, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         bus.req_pwr_up = (i == 5);
         step("drain_busy", DRAIN, 1'b0, 1'b0);
      end
      bus.req_pwr_up = 1'b0;
      bus.link_busy  = 1'b0;
      for (int i = 0; i < 4; i++) step("drain_idle", DRAIN, 1'b0, 1'b0);
      step("drain_iso", ISO, 1'b0, 1'b0);
      step("drain_pwr_off", PWR_OFF_WAIT, 1'b0, 1'b0);
      step("drain_ack_hold", PWR_OFF_WAIT, 1'b0, 1'b0);
      bus.pwr_ack      = 1'b0;
      bus.req_pwr_down = 1'b0;
      step("drain_off", OFF, 1'b1, 1'b0);
      step("drain_off_hold", OFF, 1'b0, 1'b0);

      // abort a drain stuck on a busy link
      power_up("power_up2");
      bus.req_pwr_down = 1'b1;
      bus.link_busy    = 1'b1;
      step("abort_drain", DRAIN, 1'b0, 1'b0);
      step("abort_drain", DRAIN, 1'b0, 1'b0);
      bus.req_pwr_down = 1'b0;
      bus.req_pwr_up   = 1'b1;
      step("abort_on", ON, 1'b0, 1'b0);
      step("abort_on_hold", ON, 1'b0, 1'b0);
      bus.req_pwr_up = 1'b0;
      bus.link_busy  = 1'b0;

      // asynchronous reset while ON
      arst = 1'b1;
      #1;
      expect_st("arst_async", OFF, 1'b0, 1'b0);
      score();
      @(posedge ck);
      #1;
      arst = 1'b0;
      step("arst_release", OFF, 1'b0, 1'b0);

      // power-on ack timeout: 16 counted cycles, error on the return to OFF
      bus.pwr_ack    = 1'b0;
      bus.req_pwr_up = 1'b1;
      step("timeout_entry", PWR_ON_WAIT, 1'b0, 1'b0);
      bus.req_pwr_up = 1'b0;
      for (int i = 0; i < 16; i++) step("timeout_wait", PWR_ON_WAIT, 1'b0, 1'b0);
      step("timeout_err", OFF, 1'b1, 1'b1);
      step("timeout_err_hold", OFF, 1'b0, 1'b1);

      // new request clears the error; an ack glitch restarts the settle count
      bus.req_pwr_up = 1'b1;
      step("err_clear", PWR_ON_WAIT, 1'b0, 1'b0);
      bus.req_pwr_up = 1'b0;
      for (int k = 20; k <= 32; k++) begin
         bus.pwr_ack = (k <= 23) || (k >= 25);
         step("glitch_settle", PWR_ON_WAIT, 1'b0, 1'b0);
      end
      step("glitch_deiso", DEISO, 1'b0, 1'b0);
      step("glitch_on", ON, 1'b1, 1'b0);

      // power-off ack timeout: supply never reports down
      bus.req_pwr_down = 1'b1;
      bus.link_busy    = 1'b0;
      step("off_to_drain", DRAIN, 1'b0, 1'b0);
      bus.req_pwr_down = 1'b0;
      for (int i = 0; i < 4; i++) step("off_to_idle", DRAIN, 1'b0, 1'b0);
      step("off_to_iso", ISO, 1'b0, 1'b0);
      step("off_to_wait", PWR_OFF_WAIT, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step("off_to_wait", PWR_OFF_WAIT, 1'b0, 1'b0);
      step("off_to_err", OFF, 1'b1, 1'b1);
      step("off_to_err_hold", OFF, 1'b0, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
